// File: rtl/mdu_ctrl.sv
// Multiply/divide unit controller: single-cycle 32x32 multiply, 32-step
// restoring divide, with pipeline stall, flush (cancel) and result hold.
module mdu_ctrl #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic [DATA_W-1:0] src_a,
  input  logic [DATA_W-1:0] src_b,
  input  logic              cancel,
  output logic              stallreq,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] hi_out,
  output logic [DATA_W-1:0] lo_out
);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  localparam logic [DATA_W-1:0] ONE  = {{(DATA_W-1){1'b0}}, 1'b1};
  localparam logic [5:0]        LAST = 6'(DATA_W - 1);

  // Two's-complement negation when n is set; magnitude of 0x8000_0000 stays
  // 0x8000_0000, which is the correct unsigned magnitude.
  function automatic logic [DATA_W-1:0] neg_if(input logic [DATA_W-1:0] v,
                                               input logic              n);
    return n ? (~v + ONE) : v;
  endfunction

  state_t state_q, state_d;
  logic [5:0] cnt_q;

  // Operands latched at accept; later changes on src_a/src_b/op are ignored.
  logic [DATA_W-1:0] a_q, b_q;
  logic              sgn_q;       // signed operation (MULT/DIV)
  logic              qneg_q;      // negate quotient
  logic              rneg_q;      // negate remainder
  logic              dvs_zero_q;  // divisor was zero

  // Restoring divider: quo_q starts as dividend magnitude and shifts out its
  // MSB each step while quotient bits shift in at the LSB.
  logic [DATA_W-1:0] rem_q, quo_q, dvs_q;

  logic              accept, div_step, load_res;
  logic [DATA_W-1:0] res_hi, res_lo;

  logic signed [DATA_W:0]     mul_a, mul_b;
  logic signed [2*DATA_W-1:0] prod;
  logic [DATA_W:0]            partial, diff;
  logic                       fits;
  logic [DATA_W-1:0]          rem_n, quo_n;

  // Datapath arithmetic: 64-bit product and one restoring-division step.
  always_comb begin
    mul_a   = {sgn_q & a_q[DATA_W-1], a_q};
    mul_b   = {sgn_q & b_q[DATA_W-1], b_q};
    prod    = mul_a * mul_b;
    partial = {rem_q, quo_q[DATA_W-1]};
    diff    = partial - {1'b0, dvs_q};
    fits    = ~diff[DATA_W];
    rem_n   = fits ? diff[DATA_W-1:0] : partial[DATA_W-1:0];
    quo_n   = {quo_q[DATA_W-2:0], fits};
  end

  // Next-state, handshake outputs and result selection.
  always_comb begin
    state_d  = state_q;
    stallreq = 1'b0;
    busy     = (state_q != IDLE);
    done     = (state_q == DONE);
    accept   = 1'b0;
    div_step = 1'b0;
    load_res = 1'b0;
    res_hi   = hi_out;
    res_lo   = lo_out;
    case (state_q)
      IDLE: begin
        if (start && !cancel) begin
          accept   = 1'b1;
          stallreq = 1'b1;
          state_d  = op[1] ? DIV : MUL;
        end
      end
      MUL: begin
        if (cancel) begin
          state_d = IDLE;
        end else begin
          stallreq = 1'b1;
          load_res = 1'b1;
          res_hi   = prod[2*DATA_W-1:DATA_W];
          res_lo   = prod[DATA_W-1:0];
          state_d  = DONE;
        end
      end
      DIV: begin
        if (cancel) begin
          state_d = IDLE;
        end else begin
          stallreq = 1'b1;
          if (dvs_zero_q) begin
            load_res = 1'b1;
            res_hi   = a_q;
            res_lo   = '1;
            state_d  = DONE;
          end else begin
            div_step = 1'b1;
            if (cnt_q == LAST) begin
              load_res = 1'b1;
              res_hi   = neg_if(rem_n, rneg_q);
              res_lo   = neg_if(quo_n, qneg_q);
              state_d  = DONE;
            end
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // Reset overrides start, cancel and any operation in flight.
    if (rst) begin
      state_d  = IDLE;
      stallreq = 1'b0;
      accept   = 1'b0;
      div_step = 1'b0;
      load_res = 1'b0;
    end
  end

  // Control state: FSM, iteration counter and the visible result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hi_out  <= '0;
      lo_out  <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        cnt_q <= '0;
      end else if (div_step) begin
        cnt_q <= cnt_q + 6'd1;
      end
      if (load_res) begin
        hi_out <= res_hi;
        lo_out <= res_lo;
      end
    end
  end

  // Operand capture at accept and divider shift registers.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_q        <= src_a;
      b_q        <= src_b;
      sgn_q      <= ~op[0];
      qneg_q     <= ~op[0] & (src_a[DATA_W-1] ^ src_b[DATA_W-1]);
      rneg_q     <= ~op[0] & src_a[DATA_W-1];
      dvs_zero_q <= (src_b == '0);
      rem_q      <= '0;
      quo_q      <= neg_if(src_a, ~op[0] & src_a[DATA_W-1]);
      dvs_q      <= neg_if(src_b, ~op[0] & src_b[DATA_W-1]);
    end else if (div_step) begin
      rem_q <= rem_n;
      quo_q <= quo_n;
    end
  end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Bench for mdu_ctrl: transaction-level reference model, per-cycle compare,
// directed literal cases and randomized traffic with cancel and reset.
module tb_mdu_ctrl;

  logic        clk = 1'b0;
  logic        rst, start, cancel;
  logic [1:0]  op;
  logic [31:0] src_a, src_b;
  logic        stallreq, busy, done;
  logic [31:0] hi_out, lo_out;

  mdu_ctrl #(.DATA_W(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .src_a(src_a), .src_b(src_b),
    .cancel(cancel), .stallreq(stallreq), .busy(busy), .done(done),
    .hi_out(hi_out), .lo_out(lo_out)
  );

  always #5 clk = ~clk;

  // Reference model: mode 0 idle, 1 computing, 2 result cycle.
  int          m_mode = 0;
  int          m_left = 0;
  logic [31:0] m_hi = '0, m_lo = '0, m_phi = '0, m_plo = '0;
  bit          m_init = 1'b0;
  int          cyc = 0, m_acc = 0;

  // Literal expectations attached to the next completed operation.
  bit          pin_en = 1'b0;
  logic [31:0] pin_hi, pin_lo;
  int          pin_lat;

  int checks = 0, errors = 0;

  function automatic void calc(input logic [1:0] o, input logic [31:0] a,
                               input logic [31:0] b,
                               output logic [31:0] h, output logic [31:0] l);
    longint      sa, sb, q, r;
    logic [63:0] p, qv, rv;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    h = '0; l = '0;
    case (o)
      2'b00: begin p = sa * sb; h = p[63:32]; l = p[31:0]; end
      2'b01: begin p = 64'(a) * 64'(b); h = p[63:32]; l = p[31:0]; end
      2'b10: begin
        if (b == 0) begin h = a; l = 32'hFFFF_FFFF; end
        else begin
          q = sa / sb; r = sa % sb; qv = q; rv = r;
          h = rv[31:0]; l = qv[31:0];
        end
      end
      default: begin
        if (b == 0) begin h = a; l = 32'hFFFF_FFFF; end
        else begin h = a % b; l = a / b; end
      end
    endcase
  endfunction

  // Advance the model on each clock edge from the inputs seen at that edge.
  always @(posedge clk) begin
    logic [31:0] h, l;
    cyc <= cyc + 1;
    if (rst) begin
      m_init <= 1'b1;
      m_mode <= 0;
      m_hi   <= '0;
      m_lo   <= '0;
    end else begin
      case (m_mode)
        0: if (start && !cancel) begin
          calc(op, src_a, src_b, h, l);
          m_phi  <= h;
          m_plo  <= l;
          m_left <= (!op[1] || src_b == 0) ? 1 : 32;
          m_mode <= 1;
          m_acc  <= cyc;
        end
        1: if (cancel) m_mode <= 0;
           else begin
             m_left <= m_left - 1;
             if (m_left == 1) begin
               m_mode <= 2;
               m_hi   <= m_phi;
               m_lo   <= m_plo;
             end
           end
        default: m_mode <= 0;
      endcase
    end
  end

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  // Compare DUT outputs with the model on every cycle, away from the edge.
  always @(negedge clk) begin
    if (m_init) begin
      check("stallreq", 32'(stallreq),
            32'(!rst && ((m_mode == 0 && start && !cancel) || (m_mode == 1 && !cancel))));
      check("busy", 32'(busy), 32'(m_mode != 0));
      check("done", 32'(done), 32'(m_mode == 2));
      check("hi_out", hi_out, m_hi);
      check("lo_out", lo_out, m_lo);
      if (pin_en && m_mode == 2) begin
        check("pin_latency", 32'(cyc - m_acc), 32'(pin_lat));
        check("pin_hi_dut", hi_out, pin_hi);
        check("pin_lo_dut", lo_out, pin_lo);
        check("pin_hi_model", m_hi, pin_hi);
        check("pin_lo_model", m_lo, pin_lo);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rnd_val();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'($urandom_range(0, 20));
      5: return -32'($urandom_range(1, 20));
      default: return $urandom;
    endcase
  endfunction

  // Accept an op, then hold start high and scramble operands until done.
  task automatic issue(input logic [1:0] o, input logic [31:0] a,
                       input logic [31:0] b, input int lat,
                       input logic [31:0] ph, input logic [31:0] pl);
    pin_hi = ph; pin_lo = pl; pin_lat = lat; pin_en = 1'b1;
    start = 1'b1; cancel = 1'b0; op = o; src_a = a; src_b = b;
    step();
    for (int k = 1; k <= lat; k++) begin
      start = 1'b1; op = 2'($urandom); src_a = $urandom; src_b = $urandom;
      step();
    end
    start = 1'b0; pin_en = 1'b0;
    step();
    step();
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; cancel = 1'b0; op = 2'b00; src_a = '0; src_b = '0;
    #1;
    step(); step(); step();
    rst = 1'b0;
    step();

    issue(2'b00, 32'hFFFF_FFFE, 32'd3, 2, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
    issue(2'b11, 32'd100, 32'd7, 33, 32'd2, 32'd14);
    issue(2'b10, 32'hFFFF_FFF9, 32'd2, 33, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    issue(2'b10, 32'd5, 32'd0, 2, 32'd5, 32'hFFFF_FFFF);
    issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2, 32'hFFFF_FFFE, 32'h0000_0001);
    issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 33, 32'h0, 32'h8000_0000);
    issue(2'b11, 32'hFFFF_FFFF, 32'd0, 2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);

    // Cancel a DIVU mid-flight, then accept a new op the cycle after.
    start = 1'b1; op = 2'b11; src_a = 32'd100; src_b = 32'd7;
    step();
    start = 1'b0;
    for (int k = 1; k < 10; k++) step();
    cancel = 1'b1;
    step();
    cancel = 1'b0;
    issue(2'b01, 32'd6, 32'd7, 2, 32'd0, 32'd42);

    // Reset in the middle of a DIV with start held high.
    start = 1'b1; op = 2'b10; src_a = 32'd1000; src_b = 32'd3;
    step();
    for (int k = 1; k < 5; k++) step();
    rst = 1'b1;
    step();
    rst = 1'b0; start = 1'b0;
    step(); step();

    // Randomized traffic.
    for (int k = 0; k < 3000; k++) begin
      rst    = ($urandom_range(0, 299) == 0);
      start  = ($urandom_range(0, 2) == 0);
      cancel = ($urandom_range(0, 79) == 0);
      op     = 2'($urandom);
      src_a  = rnd_val();
      src_b  = rnd_val();
      step();
    end
    rst = 1'b0; start = 1'b0; cancel = 1'b0;
    for (int k = 0; k < 40; k++) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mdu_ctrl.md
MDU_CTRL -- requirements
Module: mdu_ctrl

Interface
REQ-001 SHALL use reset rst, synchronous, active-high; clock clk.
REQ-002 SHALL have ports: clk  in  1  clock; rst  in  1  sync active-high reset.
REQ-003 SHALL have: start  in  1  request to begin an operation; op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-004 SHALL have: src_a  in  32  multiplicand or dividend; src_b  in  32  multiplier or divisor.
REQ-005 SHALL have: cancel  in  1  pipeline flush; abort the current operation.
REQ-006 SHALL have: stallreq  out  1  stall request to pipeline control; busy  out  1  state is not IDLE.
REQ-007 SHALL have: done  out  1  result-valid pulse; hi_out  out  32  HI result; lo_out  out  32  LO result.

Function
REQ-008 SHALL implement states IDLE, MUL, DIV, DONE.
REQ-009 Accept: start=1 in IDLE with cancel=0 -> latch op/src_a/src_b; op[1]=0 -> MUL, op[1]=1 -> DIV.
REQ-010 start SHALL be ignored in MUL, DIV and DONE.
REQ-011 MUL: one cycle; form 64-bit product (signed for MULT, unsigned for MULTU) into {hi,lo}; then DONE.
REQ-012 DIV: 32 restoring-division iterations on magnitudes, one per cycle; 6-bit iteration counter; then DONE.
REQ-013 DIV signed: quotient negated iff sign(a) XOR sign(b); remainder takes sign(a); lo=quotient, hi=remainder.
REQ-014 DIVU: operands treated as unsigned; no sign correction.
REQ-015 Divide by zero (src_b=0, DIV or DIVU): a single DIV cycle, then DONE with lo=32'hFFFF_FFFF, hi=src_a.
REQ-016 Signed overflow (DIV, 0x8000_0000 / 0xFFFF_FFFF): lo=0x8000_0000, hi=0; no exception.
REQ-017 Latency: accept in cycle T; MUL -> done=1 in T+2; DIV -> done=1 in T+33 (divisor nonzero), T+2 (divisor zero).
REQ-018 DONE: lasts exactly one cycle, done=1, then IDLE; a start in that cycle is ignored.
REQ-019 hi_out/lo_out SHALL update only on entry to DONE and hold until the next DONE.
REQ-020 stallreq SHALL be combinationally high in the accept cycle and in every MUL/DIV cycle; low in DONE and IDLE.
REQ-021 busy SHALL be high in MUL, DIV and DONE.
REQ-022 cancel=1 in MUL or DIV: IDLE next cycle; done stays 0; hi_out/lo_out unchanged; stallreq drops in the same cycle.
REQ-023 cancel=1 in DONE: done still pulses; hi_out/lo_out already updated.
REQ-024 cancel and start both high in IDLE: cancel wins; no accept; stallreq=0.
REQ-025 Operand registers SHALL be latched at accept; src_a/src_b/op changes during MUL/DIV have no effect.

Reset
REQ-026 rst=1: state=IDLE, counter=0, hi_out=0, lo_out=0, done=0, busy=0, stallreq=0, from the next edge.
REQ-027 rst SHALL override start and cancel and abort MUL/DIV with no done pulse.

Verification
REQ-028 MULT a=0xFFFF_FFFE (-2), b=3 -> done in T+2, hi=0xFFFF_FFFF, lo=0xFFFF_FFFA; stallreq high T..T+1.
REQ-029 DIVU a=100, b=7 -> done in T+33, lo=14, hi=2; stallreq high T..T+32, low at T+33.
REQ-030 DIV a=-7 (0xFFFF_FFF9), b=2 -> lo=0xFFFF_FFFD (-3), hi=0xFFFF_FFFF (-1).
REQ-031 DIV a=5, b=0 -> done in T+2, lo=0xFFFF_FFFF, hi=5.
REQ-032 DIVU 100/7, cancel at T+10 -> IDLE at T+11, no done, hi/lo keep prior values; a new start at T+11 is accepted.
REQ-033 rst at T+5 of a DIV -> all outputs 0 next cycle; start held during DONE ignored (no second done).
